// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_queue
// Purpose  : Byte FIFO plus transmit sequencer placed in front of the osdvu
//            uart core. Producers push bytes with a one-cycle strobe. Queued
//            bytes are handed to the UART one at a time, handshaking on
//            is_transmitting, so a transmit pulse is never issued while the
//            UART is busy.
// Ports    : clk, rst                - clock, synchronous active-high reset
//            wr_en, wr_data          - push strobe and byte
//            full, empty, count      - registered occupancy status
//            overflow/clear_overflow - sticky dropped-write flag and its clear
//            busy                    - sequencer active or queue non-empty
//            uart_transmit           - one-cycle start pulse to uart.transmit
//            uart_tx_byte            - byte presented to uart.tx_byte
//            uart_is_transmitting    - busy flag from the uart
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_queue #(
    parameter int DEPTH_LOG2  = 4,
    parameter int GAP_CYCLES  = 0,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clear_overflow,
    output logic                  busy,
    output logic                  uart_transmit,
    output logic [7:0]            uart_tx_byte,
    input  logic                  uart_is_transmitting
);

    localparam int                  c_depth      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_count = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] c_cnt_one    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    // Last timer value of each timed state; the timer restarts at 0 on entry.
    localparam logic [15:0] c_ack_last = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] c_gap_last = 16'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [15:0]             r_timer;
    logic [7:0]              r_mem [c_depth];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic [DEPTH_LOG2:0]     w_count_next;
    logic                    r_full;
    logic                    r_empty;
    logic                    r_overflow;
    logic [7:0]              r_tx_byte;
    logic                    w_push;
    logic                    w_pop;

    // Acceptance looks at the registered full flag only, so a write against a
    // full queue is dropped even when a pop happens in the same cycle.
    assign w_push = wr_en && !r_full;
    assign w_pop  = (r_state == ST_START);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_cnt_one;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_cnt_one;
        end
    end

    // Storage contents need no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_full_count);
            r_empty <= (w_count_next == '0);
            // A drop in the same cycle as a clear keeps the flag set.
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!r_empty && !uart_is_transmitting) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (uart_is_transmitting) begin
                    w_state_next = ST_WAIT_DONE;
                end else if (r_timer == c_ack_last) begin
                    // Byte is considered consumed; no retry.
                    w_state_next = ST_GAP;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_timer == c_gap_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= 16'd0;
            r_tx_byte <= 8'd0;
        end else begin
            r_state <= w_state_next;
            // One shared timer, restarted on every state change.
            if (w_state_next != r_state) begin
                r_timer <= 16'd0;
            end else begin
                r_timer <= r_timer + 16'd1;
            end
            // Head is captured on the way into START so the byte is already
            // valid during the transmit pulse; it then holds until the next one.
            if (r_state == ST_IDLE && w_state_next == ST_START) begin
                r_tx_byte <= r_mem[r_rd_ptr];
            end
        end
    end

    assign full          = r_full;
    assign empty         = r_empty;
    assign count         = r_count;
    assign overflow      = r_overflow;
    assign busy          = (r_state != ST_IDLE) || !r_empty;
    assign uart_transmit = (r_state == ST_START);
    assign uart_tx_byte  = r_tx_byte;

endmodule
`default_nettype wire
